// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin command sequencer guarding a NOR SR latch.
// Ports: clk, rst_n (async low); req_set/req_clr[NREQ] level requests;
//        gnt[NREQ] one-hot ack; fault/conflict ack qualifiers; err sticky;
//        busy; s/r registered latch drives (never both high); q_fb latch Q.
module sr_latch_ctrl #(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_set,
    input  logic [NREQ-1:0] req_clr,
    output logic [NREQ-1:0] gnt,
    output logic            fault,
    output logic            conflict,
    output logic            err,
    output logic            busy,
    output logic            s,
    output logic            r,
    input  logic            q_fb
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] PLOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GLOAD = CW'((GAP_W > 0) ? GAP_W - 1 : 0);
    localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, PULSE, CHECK, GAP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   win, win_n;
    logic [IW-1:0]   pick, idx;
    logic            found;
    logic            cmd_set, cmd_set_n;
    logic            cmd_clr, cmd_clr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt_n;
    logic            s_n, r_n;
    logic            fault_n, conflict_n, err_n, busy_n;

    assign elig = req_set | req_clr;

    // First eligible requester at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        win_n      = win;
        cmd_set_n  = cmd_set;
        cmd_clr_n  = cmd_clr;
        cnt_n      = cnt;
        gnt_n      = '0;
        s_n        = 1'b0;
        r_n        = 1'b0;
        fault_n    = 1'b0;
        conflict_n = 1'b0;
        err_n      = err;

        unique case (state)
            IDLE: begin
                if (found) begin
                    win_n     = pick;
                    cmd_set_n = req_set[pick];
                    cmd_clr_n = req_clr[pick];
                    ptr_n     = (pick == LAST) ? '0 : pick + 1'b1;
                    cnt_n     = PLOAD;
                    state_n   = PULSE;
                    // Both bits set decodes to a no-op pulse.
                    s_n       = req_set[pick] & ~req_clr[pick];
                    r_n       = req_clr[pick] & ~req_set[pick];
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n        = CHECK;
                    gnt_n[win]     = 1'b1;
                    conflict_n     = cmd_set & cmd_clr;
                    // Q is judged as the pulse ends so fault lines up with gnt.
                    fault_n        = ~(cmd_set & cmd_clr) & (q_fb != cmd_set);
                    err_n          = err | conflict_n | fault_n;
                end else begin
                    cnt_n = cnt - 1'b1;
                    s_n   = cmd_set & ~cmd_clr;
                    r_n   = cmd_clr & ~cmd_set;
                end
            end
            CHECK: begin
                if (GAP_W == 0) begin
                    state_n = IDLE;
                end else begin
                    state_n = GAP;
                    cnt_n   = GLOAD;
                end
            end
            GAP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            cmd_set  <= 1'b0;
            cmd_clr  <= 1'b0;
            cnt      <= '0;
            gnt      <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            fault    <= 1'b0;
            conflict <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            win      <= win_n;
            cmd_set  <= cmd_set_n;
            cmd_clr  <= cmd_clr_n;
            cnt      <= cnt_n;
            gnt      <= gnt_n;
            s        <= s_n;
            r        <= r_n;
            fault    <= fault_n;
            conflict <= conflict_n;
            err      <= err_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: scoreboard bench for sr_latch_ctrl with NOR latch models.
// Two builds: (4,2,1) directed and (3,1,0) random.
module tb_sr_latch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] req_set, req_clr, gnt;
    logic fault, conflict, err, busy, s, r, q_fb;
    logic q_lat = 1'b0;
    logic force_q0;

    logic [2:0] rs2, rc2, gnt2;
    logic fault2, conflict2, err2, busy2, s2, r2;
    logic q2_lat = 1'b0;
    logic q2_exp;

    always @(s or r) begin
        if (s)      q_lat = 1'b1;
        else if (r) q_lat = 1'b0;
    end
    always @(s2 or r2) begin
        if (s2)      q2_lat = 1'b1;
        else if (r2) q2_lat = 1'b0;
    end
    assign q_fb = force_q0 ? 1'b0 : q_lat;

    sr_latch_ctrl #(.NREQ(4), .PULSE_W(2), .GAP_W(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_set(req_set), .req_clr(req_clr),
        .gnt(gnt), .fault(fault), .conflict(conflict), .err(err),
        .busy(busy), .s(s), .r(r), .q_fb(q_fb)
    );

    sr_latch_ctrl #(.NREQ(3), .PULSE_W(1), .GAP_W(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_set(rs2), .req_clr(rc2),
        .gnt(gnt2), .fault(fault2), .conflict(conflict2), .err(err2),
        .busy(busy2), .s(s2), .r(r2), .q_fb(q2_lat)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       fault;
        logic       conflict;
    } exp_t;

    exp_t sbq[$];
    int   gnt_cyc[$];
    int   nchk = 0, nfail = 0;
    int   cyc = 0, ngnt = 0;
    int   s_cyc = 0, r_cyc = 0;
    int   t0, c, n;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic f, input logic cf);
        exp_t e;
        e.gnt = g; e.fault = f; e.conflict = cf;
        sbq.push_back(e);
    endtask

    // One cycle: sample on the falling edge, check, pop, drop acked requesters.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("s_and_r", 32'(s & r), 0);
        chk("gnt_onehot", 32'($onehot0(gnt)), 1);
        chk("s2_and_r2", 32'(s2 & r2), 0);
        chk("gnt2_onehot", 32'($onehot0(gnt2)), 1);
        if (s) s_cyc++;
        if (r) r_cyc++;
        if (gnt != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 0);
            end else begin
                e = sbq.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("fault", 32'(fault), 32'(e.fault));
                chk("conflict", 32'(conflict), 32'(e.conflict));
            end
            ngnt++;
            gnt_cyc.push_back(cyc);
            for (int i = 0; i < 4; i++)
                if (gnt[i]) begin req_set[i] = 1'b0; req_clr[i] = 1'b0; end
        end
        for (int i = 0; i < 3; i++) begin
            if (gnt2[i]) begin
                if (rs2[i] & ~rc2[i])      q2_exp = 1'b1;
                else if (rc2[i] & ~rs2[i]) q2_exp = 1'b0;
                chk("q2_model", 32'(q2_lat), 32'(q2_exp));
                chk("conflict2", 32'(conflict2), 32'(rs2[i] & rc2[i]));
                chk("fault2", 32'(fault2), 0);
                rs2[i] = 1'b0;
                rc2[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_gnts(input int k, input int budget);
        int target = ngnt + k;
        int b = 0;
        while (ngnt < target && b < budget) begin tick(); b++; end
        chk("gnt_timeout", 32'(ngnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget, output int cnt);
        cnt = 0;
        while (busy && cnt < budget) begin tick(); cnt++; end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_reset();
        req_set = '0;
        req_clr = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s"}, 32'(s), 0);
        chk({tag, "_r"}, 32'(r), 0);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_conflict"}, 32'(conflict), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        force_q0 = 1'b0;
        req_set = '0; req_clr = '0;
        rs2 = '0; rc2 = '0;
        q2_exp = 1'b0;
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single set on requester 0.
        s_cyc = 0; r_cyc = 0; t0 = cyc;
        req_set[0] = 1'b1;
        push(4'b0001, 1'b0, 1'b0);
        wait_gnts(1, 30);
        chk("set_latency", 32'(gnt_cyc[$] - t0), 3);
        chk("set_s_cycles", 32'(s_cyc), 2);
        chk("set_r_cycles", 32'(r_cyc), 0);
        chk("set_q", 32'(q_fb), 1);
        wait_idle(20, c);
        chk("busy_after_gnt", 32'(c), 2);

        // Single clear on requester 2.
        s_cyc = 0; r_cyc = 0;
        req_clr[2] = 1'b1;
        push(4'b0100, 1'b0, 1'b0);
        wait_gnts(1, 30);
        chk("clr_r_cycles", 32'(r_cyc), 2);
        chk("clr_s_cycles", 32'(s_cyc), 0);
        chk("clr_q", 32'(q_fb), 0);
        wait_idle(20, c);

        // Round robin, all four from ptr=0.
        do_reset();
        req_set = 4'b1111;
        push(4'b0001, 1'b0, 1'b0);
        push(4'b0010, 1'b0, 1'b0);
        push(4'b0100, 1'b0, 1'b0);
        push(4'b1000, 1'b0, 1'b0);
        wait_gnts(4, 80);
        n = gnt_cyc.size();
        for (int k = 1; k < 4; k++)
            chk("rr_spacing", 32'(gnt_cyc[n-4+k] - gnt_cyc[n-5+k]), 5);
        wait_idle(20, c);

        // Sparse round robin: 1 then 3.
        do_reset();
        req_set = 4'b1010;
        push(4'b0010, 1'b0, 1'b0);
        push(4'b1000, 1'b0, 1'b0);
        wait_gnts(2, 40);
        wait_idle(20, c);

        // Conflict on requester 1: no pulse, Q unchanged, err sticks.
        s_cyc = 0; r_cyc = 0;
        req_set[1] = 1'b1; req_clr[1] = 1'b1;
        push(4'b0010, 1'b0, 1'b1);
        wait_gnts(1, 30);
        chk("conf_s_cycles", 32'(s_cyc), 0);
        chk("conf_r_cycles", 32'(r_cyc), 0);
        chk("conf_q", 32'(q_fb), 1);
        wait_idle(20, c);
        tick(); tick();
        chk("conf_err_sticky", 32'(err), 1);

        // Fault: Q held low against a set.
        do_reset();
        chk("err_cleared", 32'(err), 0);
        force_q0 = 1'b1;
        req_set[3] = 1'b1;
        push(4'b1000, 1'b1, 1'b0);
        wait_gnts(1, 30);
        wait_idle(20, c);
        chk("fault_err", 32'(err), 1);
        force_q0 = 1'b0;
        req_clr[0] = 1'b1;
        push(4'b0001, 1'b0, 1'b0);
        wait_gnts(1, 30);
        wait_idle(20, c);
        chk("fault_err_kept", 32'(err), 1);
        chk("fault_q", 32'(q_fb), 0);

        // Reset mid-pulse: ptr=2, reqs 2,3 held; after reset 2 wins again.
        do_reset();
        req_set[1] = 1'b1;
        push(4'b0010, 1'b0, 1'b0);
        wait_gnts(1, 30);
        wait_idle(20, c);
        req_set[2] = 1'b1; req_set[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_s_high", 32'(s), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        push(4'b0100, 1'b0, 1'b0);
        push(4'b1000, 1'b0, 1'b0);
        wait_gnts(2, 40);
        wait_idle(20, c);

        // Random traffic on the (3,1,0) build.
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(rs2[i] | rc2[i]) && $urandom_range(2) == 0) begin
                    case ($urandom_range(3))
                        0:       rs2[i] = 1'b1;
                        1:       rc2[i] = 1'b1;
                        2:       begin rs2[i] = 1'b1; rc2[i] = 1'b1; end
                        default: ;
                    endcase
                end
            end
            tick();
        end
        chk("dut1_quiet", 32'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
